// File: rtl/sync_filter_bank_pkg.sv
// Shared constants and elaboration-time helpers for the synchroniser bank.
package sync_filter_bank_pkg;

    // Fewest flops a synchroniser chain may have and still be a synchroniser.
    localparam int SYNC_MIN_STAGES = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Width of the glitch-filter counter: it counts 0..cycles-1, never narrower than 1 bit.
    function automatic int filter_cnt_width(input int cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_filter_bank_if.sv
// Signal bundle of the synchroniser bank.
// There is no valid/ready handshake here: async_i is a free-running level with
// no timing relation to the destination clock, level_o is a registered level,
// and rise_o/fall_o are single-cycle registered pulses marking level_o edges.
interface sync_filter_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] async_i;
    logic [CHANNELS-1:0] level_o;
    logic [CHANNELS-1:0] rise_o;
    logic [CHANNELS-1:0] fall_o;

    // Source side: drives the asynchronous levels, observes the results.
    modport master (
        output async_i,
        input  level_o,
        input  rise_o,
        input  fall_o
    );

    // Synchroniser side.
    modport slave (
        input  async_i,
        output level_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/sync_filter_channel.sv
// One synchroniser channel: N-flop chain, consecutive-sample glitch filter,
// registered level and registered rise/fall pulses.
module sync_filter_channel
    import sync_filter_bank_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 1,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W   = filter_cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchroniser flops: pure register chain, nothing between stages so the
    // tools can place them back to back.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic             sync_s;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             fall_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous input through the chain; stage 0 is the capture flop.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Filter decision: the level follows the synchronised sample only after it
    // has differed for FILTER_CYCLES consecutive samples; any agreement restarts
    // the count, so a short glitch leaves no trace.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_s != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_s;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Level, counter and edge pulses all update on the same edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel clock-domain entry synchroniser: CHANNELS independent copies
// of sync_filter_channel behind one signal bundle. Every output is a flop
// output, so async_i never reaches an output combinationally.
module sync_filter_bank
    import sync_filter_bank_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 1,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input logic               clk_i,
    input logic               resetn_i,
    sync_filter_bank_if.slave bus
);

    // Reject configurations that would not synchronise or filter at all.
    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_filter_bank: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_bank: SYNC_STAGES must be >= %0d", SYNC_MIN_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter_bank: FILTER_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;

    // One fully independent channel per input bit.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sync_filter_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VALUE[c])
        ) u_chan (
            .clk_i    (clk_i),
            .resetn_i (resetn_i),
            .async_i  (bus.async_i[c]),
            .level_o  (level_w[c]),
            .rise_o   (rise_w[c]),
            .fall_o   (fall_w[c])
        );
    end

    assign bus.level_o = level_w;
    assign bus.rise_o  = rise_w;
    assign bus.fall_o  = fall_w;

endmodule
